// File: rtl/ipbus_pkt_pkg.sv
// rtl/ipbus_pkt_pkg.sv - shared state encoding, default header layout and header word map
package ipbus_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WR,
        ENGINE,
        SEND,
        RELEASE
    } pkt_state_e;

    localparam int DEF_HDR_WORDS = 13;
    localparam int DEF_SWAP_A    = 7;
    localparam int DEF_SWAP_B    = 8;
    localparam int DEF_PORT_WORD = 9;

    // Request word that feeds response header word wc: the two MAC words trade places.
    function automatic int src(input int wc, input int swap_a, input int swap_b);
        if (wc == swap_a) begin
            return swap_b;
        end else if (wc == swap_b) begin
            return swap_a;
        end
        return wc;
    endfunction

endpackage

// File: rtl/ipbus_rr_arbiter.sv
// rtl/ipbus_rr_arbiter.sv - round-robin slot picker starting after the last granted slot
module ipbus_rr_arbiter #(
    parameter int NSLOT  = 2,
    parameter int SLOT_W = $clog2(NSLOT)
) (
    input  logic [NSLOT-1:0]  req,
    input  logic [NSLOT-1:0]  mask,
    input  logic [SLOT_W-1:0] last_grant,
    output logic [NSLOT-1:0]  grant,
    output logic [SLOT_W-1:0] grant_idx
);

    logic [NSLOT-1:0]  eligible;
    logic [SLOT_W-1:0] cand;

    assign eligible = req & ~mask;

    // Walk the slots from last_grant+1 around to last_grant and keep the first eligible one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NSLOT; i++) begin
            cand = last_grant + SLOT_W'(i);
            if (grant == '0 && eligible[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ipbus_pkt_sequencer.sv
// rtl/ipbus_pkt_sequencer.sv - multi-slot header copy, engine window and release sequencer (optional watchdog: PKTSEQ_TIMEOUT_EN)
module ipbus_pkt_sequencer
    import ipbus_pkt_pkg::*;
#(
    parameter int AWIDTH         = 9,
    parameter int NSLOT          = 2,
    parameter int HDR_WORDS      = DEF_HDR_WORDS,
    parameter int SWAP_A         = DEF_SWAP_A,
    parameter int SWAP_B         = DEF_SWAP_B,
    parameter int PORT_WORD      = DEF_PORT_WORD,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SLOT_W        = $clog2(NSLOT)
) (
    input  logic                     ipb_clk,
    input  logic                     reset,
    input  logic [NSLOT-1:0]         rx_valid,
    output logic                     rx_free,
    output logic [SLOT_W-1:0]        rx_free_slot,
    output logic [SLOT_W+AWIDTH-1:0] req_addr,
    input  logic [31:0]              req_data,
    output logic [SLOT_W+AWIDTH-1:0] resp_addr,
    output logic [31:0]              resp_data,
    output logic                     resp_we,
    output logic                     eng_active,
    input  logic [AWIDTH-1:0]        eng_req_addr,
    output logic [31:0]              eng_req_data,
    input  logic [AWIDTH-1:0]        eng_resp_addr,
    input  logic [31:0]              eng_resp_data,
    input  logic                     eng_resp_we,
    input  logic [AWIDTH-1:0]        eng_resp_len,
    input  logic                     eng_done,
    output logic                     tx_req,
    input  logic                     tx_ack,
    output logic [SLOT_W-1:0]        tx_slot,
    output logic [AWIDTH-1:0]        tx_len,
    output logic [7:0]               err_count
);

    localparam logic [AWIDTH-1:0] HDR_OFS  = AWIDTH'(HDR_WORDS);
    localparam logic [AWIDTH-1:0] HDR_LAST = AWIDTH'(HDR_WORDS - 1);
    localparam logic [AWIDTH-1:0] PORT_IDX = AWIDTH'(PORT_WORD);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ipbus_pkt_sequencer: TIMEOUT_CYCLES must be at least 1");
    end
    if (NSLOT < 2 || (NSLOT & (NSLOT - 1)) != 0) begin : g_bad_nslot
        $error("ipbus_pkt_sequencer: NSLOT must be a power of two, at least 2");
    end
    if (HDR_WORDS < 10) begin : g_bad_hdr
        $error("ipbus_pkt_sequencer: HDR_WORDS must be at least 10");
    end

    pkt_state_e          state, state_n;
    logic [SLOT_W-1:0]   cur_slot, last_slot;
    logic [AWIDTH-1:0]   wc;
    logic [AWIDTH-1:0]   tx_len_q;
    logic                rel_mask_q;
    logic [NSLOT-1:0]    rel_mask;
    logic [NSLOT-1:0]    arb_grant;
    logic [SLOT_W-1:0]   arb_idx;
    logic                arb_valid;
    logic [AWIDTH-1:0]   hdr_src;
    logic                timeout_hit;

    // The slot released last cycle is still flagged valid upstream; hide it for one cycle.
    assign rel_mask  = rel_mask_q ? (NSLOT'(1) << last_slot) : '0;
    assign arb_valid = |arb_grant;
    assign hdr_src   = AWIDTH'(src(32'(wc), SWAP_A, SWAP_B));
    assign tx_len    = tx_len_q;

    ipbus_rr_arbiter #(
        .NSLOT  (NSLOT),
        .SLOT_W (SLOT_W)
    ) u_arb (
        .req        (rx_valid),
        .mask       (rel_mask),
        .last_grant (last_slot),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // State register plus the per-packet slot, word counter and response length latches.
    always_ff @(posedge ipb_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_slot   <= '0;
            last_slot  <= SLOT_W'(NSLOT - 1);
            wc         <= '0;
            tx_len_q   <= '0;
            rel_mask_q <= 1'b0;
        end else begin
            state      <= state_n;
            rel_mask_q <= (state == RELEASE);
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        cur_slot <= arb_idx;
                        wc       <= '0;
                    end
                end
                HDR_WR: begin
                    if (wc != HDR_LAST) begin
                        wc <= wc + AWIDTH'(1);
                    end
                end
                ENGINE: begin
                    if (eng_done) begin
                        tx_len_q <= eng_resp_len + HDR_OFS;
                    end
                end
                RELEASE: last_slot <= cur_slot;
                default: ;
            endcase
        end
    end

    // Next state and all RAM / engine / transmit outputs, zero unless the state drives them.
    always_comb begin
        state_n      = state;
        req_addr     = '0;
        resp_addr    = '0;
        resp_data    = '0;
        resp_we      = 1'b0;
        eng_active   = 1'b0;
        eng_req_data = '0;
        tx_req       = 1'b0;
        tx_slot      = '0;
        rx_free      = 1'b0;
        rx_free_slot = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_n = HDR_RD;
                end
            end
            HDR_RD: begin
                req_addr = {cur_slot, hdr_src};
                state_n  = HDR_WR;
            end
            HDR_WR: begin
                resp_addr = {cur_slot, wc};
                resp_we   = 1'b1;
                resp_data = (wc == PORT_IDX) ? {req_data[15:0], req_data[31:16]} : req_data;
                state_n   = (wc == HDR_LAST) ? ENGINE : HDR_RD;
            end
            ENGINE: begin
                eng_active   = 1'b1;
                req_addr     = {cur_slot, eng_req_addr + HDR_OFS};
                resp_addr    = {cur_slot, eng_resp_addr + HDR_OFS};
                resp_data    = eng_resp_data;
                resp_we      = eng_resp_we;
                eng_req_data = req_data;
                if (eng_done) begin
                    state_n = SEND;
                end else if (timeout_hit) begin
                    state_n = RELEASE;
                end
            end
            SEND: begin
                tx_req  = 1'b1;
                tx_slot = cur_slot;
                if (tx_ack) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                rx_free      = 1'b1;
                rx_free_slot = cur_slot;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef PKTSEQ_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic [7:0]  err_q;

    assign timeout_hit = (state == ENGINE) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign err_count   = err_q;

    // Engine watchdog: counts cycles spent in ENGINE and tallies aborted packets, saturating.
    always_ff @(posedge ipb_clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= '0;
        end else begin
            to_cnt <= (state == ENGINE) ? to_cnt + 32'd1 : '0;
            if (timeout_hit && !eng_done && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_count   = '0;
`endif

endmodule
